// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory request arbiter: FSM states,
// grant identifiers, IO region tag and transfer size encodings.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_UART_WAIT
    } state_e;

    typedef enum logic [1:0] {
        G_NONE,
        G_FETCH,
        G_LOAD,
        G_STORE
    } grant_e;

    localparam logic [1:0] IO_BASE_HI = 2'b11;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    function automatic logic is_io(
        input logic [31:0] addr,
        input logic [1:0]  hi
    );
        return addr[17:16] == hi;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational winner select: store > load > fetch, with fetch
// promoted to the top when it has been starved too long.
module mem_arb_prio
    import mem_arbiter_pkg::*;
(
    input  logic       fetch_req_i,
    input  logic       load_req_i,
    input  logic       store_req_i,
    input  logic [2:0] mask_i,
    input  logic       starve_i,
    output grant_e     win_o,
    output logic       fetch_act_o
);

    logic f_act;
    logic l_act;
    logic s_act;

    // mask_i is {store, load, fetch}
    assign f_act = fetch_req_i & ~mask_i[0];
    assign l_act = load_req_i  & ~mask_i[1];
    assign s_act = store_req_i & ~mask_i[2];

    assign fetch_act_o = f_act;

    always_comb begin
        win_o = G_NONE;
        if (starve_i && f_act) begin
            win_o = G_FETCH;
        end else if (s_act) begin
            win_o = G_STORE;
        end else if (l_act) begin
            win_o = G_LOAD;
        end else if (f_act) begin
            win_o = G_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load/store scheduler in front of the byte-serial RAM engine.
// Optional perf counters are enabled with `define ARB_PERF_CNT_EN.
module mem_arbiter #(
    parameter int         STARVE_LIMIT = 4,
    parameter logic [1:0] IO_BASE_HI   = mem_arbiter_pkg::IO_BASE_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rob_misbranch,
    input  logic        in_uart_full,
    input  logic        in_fetch_req,
    input  logic [31:0] in_fetch_addr,
    output logic        out_fetch_ack,
    input  logic        in_load_req,
    input  logic [31:0] in_load_addr,
    input  logic [2:0]  in_load_size,
    input  logic        in_load_signed,
    output logic        out_load_ack,
    input  logic        in_store_req,
    input  logic [31:0] in_store_addr,
    input  logic [2:0]  in_store_size,
    input  logic [31:0] in_store_data,
    output logic        out_store_ack,
    output logic [31:0] out_rdata,
    output logic        out_eng_valid,
    output logic        out_eng_rw,
    output logic [31:0] out_eng_addr,
    output logic [2:0]  out_eng_size,
    output logic        out_eng_signed,
    output logic [31:0] out_eng_wdata,
    input  logic        in_eng_done,
    input  logic [31:0] in_eng_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] out_perf_fetch,
    output logic [31:0] out_perf_load,
    output logic [31:0] out_perf_store,
    output logic [31:0] out_perf_uart_stall
`endif
);

    import mem_arbiter_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic            sgn_q, sgn_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            fack_q, fack_d;
    logic            lack_q, lack_d;
    logic            sack_q, sack_d;
    logic            kill_q, kill_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;

    grant_e          win;
    logic            fetch_act;
    logic            starve;
    logic            rd_grant;

    assign starve   = starve_cnt_q == CW'(STARVE_LIMIT);
    assign rd_grant = grant_q != G_STORE;

    mem_arb_prio u_prio (
        .fetch_req_i (in_fetch_req),
        .load_req_i  (in_load_req),
        .store_req_i (in_store_req),
        .mask_i      ({sack_q, lack_q, fack_q}),
        .starve_i    (starve),
        .win_o       (win),
        .fetch_act_o (fetch_act)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        fack_d       = fack_q;
        lack_d       = lack_q;
        sack_d       = sack_q;
        kill_d       = kill_q;
        starve_cnt_d = starve_cnt_q;
        if (rdy) begin
            fack_d = 1'b0;
            lack_d = 1'b0;
            sack_d = 1'b0;
            if (in_rob_misbranch) begin
                starve_cnt_d = '0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (!in_rob_misbranch && win != G_NONE) begin
                        grant_d = win;
                        unique case (win)
                            G_STORE: begin
                                addr_d  = in_store_addr;
                                size_d  = in_store_size;
                                sgn_d   = 1'b0;
                                wdata_d = in_store_data;
                            end
                            G_LOAD: begin
                                addr_d  = in_load_addr;
                                size_d  = in_load_size;
                                sgn_d   = in_load_signed;
                                wdata_d = '0;
                            end
                            G_FETCH: begin
                                addr_d  = in_fetch_addr;
                                size_d  = SZ_WORD;
                                sgn_d   = 1'b0;
                                wdata_d = '0;
                            end
                            default: ;
                        endcase
                        if (win == G_FETCH || !fetch_act) begin
                            starve_cnt_d = '0;
                        end else if (!starve) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                        if (win == G_STORE && in_uart_full &&
                            is_io(in_store_addr, IO_BASE_HI)) begin
                            state_d = S_UART_WAIT;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_UART_WAIT: begin
                    if (!in_uart_full) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (in_rob_misbranch && rd_grant) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (in_rob_misbranch) begin
                        kill_d = 1'b1;
                    end
                    if (in_eng_done) begin
                        state_d = S_IDLE;
                        kill_d  = 1'b0;
                        // a flushed read still drains the engine but is dropped
                        if (!rd_grant) begin
                            sack_d = 1'b1;
                        end else if (!kill_q && !in_rob_misbranch) begin
                            rdata_d = in_eng_rdata;
                            fack_d  = grant_q == G_FETCH;
                            lack_d  = grant_q == G_LOAD;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= G_NONE;
            addr_q       <= '0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            fack_q       <= 1'b0;
            lack_q       <= 1'b0;
            sack_q       <= 1'b0;
            kill_q       <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            fack_q       <= fack_d;
            lack_q       <= lack_d;
            sack_q       <= sack_d;
            kill_q       <= kill_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign out_eng_valid  = (state_q == S_ISSUE) &&
                            !(rdy && in_rob_misbranch && rd_grant);
    assign out_eng_rw     = grant_q == G_STORE;
    assign out_eng_addr   = addr_q;
    assign out_eng_size   = size_q;
    assign out_eng_signed = sgn_q;
    assign out_eng_wdata  = wdata_q;
    assign out_rdata      = rdata_q;
    assign out_fetch_ack  = fack_q;
    assign out_load_ack   = lack_q;
    assign out_store_ack  = sack_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] pf_q, pl_q, ps_q, pu_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_q <= '0;
            pl_q <= '0;
            ps_q <= '0;
            pu_q <= '0;
        end else if (rdy) begin
            if (fack_d) pf_q <= pf_q + 32'd1;
            if (lack_d) pl_q <= pl_q + 32'd1;
            if (sack_d) ps_q <= ps_q + 32'd1;
            if (state_q == S_UART_WAIT) pu_q <= pu_q + 32'd1;
        end
    end

    assign out_perf_fetch      = pf_q;
    assign out_perf_load       = pl_q;
    assign out_perf_store      = ps_q;
    assign out_perf_uart_stall = pu_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural engine model
// and requesters that drop their request the cycle after ack.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } eng_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] rdata;
    } ack_t;

    logic        clk, rst, rdy;
    logic        in_rob_misbranch, in_uart_full;
    logic        in_fetch_req, out_fetch_ack;
    logic [31:0] in_fetch_addr;
    logic        in_load_req, in_load_signed, out_load_ack;
    logic [31:0] in_load_addr;
    logic [2:0]  in_load_size;
    logic        in_store_req, out_store_ack;
    logic [31:0] in_store_addr, in_store_data;
    logic [2:0]  in_store_size;
    logic [31:0] out_rdata;
    logic        out_eng_valid, out_eng_rw, out_eng_signed;
    logic [31:0] out_eng_addr, out_eng_wdata;
    logic [2:0]  out_eng_size;
    logic        in_eng_done;
    logic [31:0] in_eng_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] pf, pl, ps, pu;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   t_valid = 0, t_done = 0, t_ack = 0, t_st_valid = 0;
    int   busy_cnt = 0;
    int   eng_lat = 3;
    logic use_fixed = 1'b0;
    logic [31:0] fixed_rdata = '0;
    logic [31:0] cur_addr = '0;
    int   fetch_reps = 0, load_reps = 0, store_reps = 0;
    bit   drop_f = 0, drop_l = 0, drop_s = 0;

    eng_t exp_eng[$];
    ack_t exp_ack[$];

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_rob_misbranch (in_rob_misbranch),
        .in_uart_full     (in_uart_full),
        .in_fetch_req     (in_fetch_req),
        .in_fetch_addr    (in_fetch_addr),
        .out_fetch_ack    (out_fetch_ack),
        .in_load_req      (in_load_req),
        .in_load_addr     (in_load_addr),
        .in_load_size     (in_load_size),
        .in_load_signed   (in_load_signed),
        .out_load_ack     (out_load_ack),
        .in_store_req     (in_store_req),
        .in_store_addr    (in_store_addr),
        .in_store_size    (in_store_size),
        .in_store_data    (in_store_data),
        .out_store_ack    (out_store_ack),
        .out_rdata        (out_rdata),
        .out_eng_valid    (out_eng_valid),
        .out_eng_rw       (out_eng_rw),
        .out_eng_addr     (out_eng_addr),
        .out_eng_size     (out_eng_size),
        .out_eng_signed   (out_eng_signed),
        .out_eng_wdata    (out_eng_wdata),
        .in_eng_done      (in_eng_done),
        .in_eng_rdata     (in_eng_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .out_perf_fetch      (pf),
        .out_perf_load       (pl),
        .out_perf_store      (ps),
        .out_perf_uart_stall (pu)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // engine model: latches the command, answers eng_lat cycles later
    initial begin
        eng_t got, e;
        in_eng_done  = 1'b0;
        in_eng_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            in_eng_done = 1'b0;
            if (rst) begin
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    in_eng_done  = 1'b1;
                    in_eng_rdata = use_fixed ? fixed_rdata : ~cur_addr;
                    t_done       = cyc;
                end
            end else if (out_eng_valid) begin
                n_valid++;
                t_valid  = cyc;
                busy_cnt = eng_lat;
                cur_addr = out_eng_addr;
                if (out_eng_rw) t_st_valid = cyc;
                got = '{out_eng_rw, out_eng_addr, out_eng_size,
                        out_eng_signed, out_eng_wdata};
                checks++;
                if (exp_eng.size() == 0) begin
                    failures++;
                    $display("FAIL eng_unexpected got=%h", got);
                end else begin
                    e = exp_eng.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL eng_fields got=%h want=%h", got, e);
                    end
                end
            end
        end
    end

    // ack monitor and requester model
    initial begin
        ack_t a;
        int   nack;
        logic [1:0] gid;
        forever begin
            @(posedge clk);
            #2;
            if (drop_f) begin in_fetch_req = 1'b0; drop_f = 0; end
            if (drop_l) begin in_load_req  = 1'b0; drop_l = 0; end
            if (drop_s) begin in_store_req = 1'b0; drop_s = 0; end
            nack = int'(out_fetch_ack) + int'(out_load_ack) +
                   int'(out_store_ack);
            if (!rst && nack > 0) begin
                checks++;
                t_ack = cyc;
                gid = out_store_ack ? 2'd3 : out_load_ack ? 2'd2 : 2'd1;
                if (nack > 1) begin
                    failures++;
                    $display("FAIL ack_multi got=%0d want=1", nack);
                end else if (exp_ack.size() == 0) begin
                    failures++;
                    $display("FAIL ack_unexpected got_id=%0d", gid);
                end else begin
                    a = exp_ack.pop_front();
                    if (a.id !== gid ||
                        (gid != 2'd3 && out_rdata !== a.rdata)) begin
                        failures++;
                        $display("FAIL ack got_id=%0d rdata=%h want_id=%0d rdata=%h",
                                 gid, out_rdata, a.id, a.rdata);
                    end
                end
                if (out_fetch_ack) begin
                    if (fetch_reps > 0) fetch_reps--; else drop_f = 1;
                end
                if (out_load_ack) begin
                    if (load_reps > 0) load_reps--; else drop_l = 1;
                end
                if (out_store_ack) begin
                    if (store_reps > 0) store_reps--; else drop_s = 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_quiet(input int budget);
        int k = 0;
        while ((exp_eng.size() != 0 || exp_ack.size() != 0 ||
                in_fetch_req || in_load_req || in_store_req ||
                busy_cnt > 0) && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL timeout got_eng=%0d got_ack=%0d want=0",
                     exp_eng.size(), exp_ack.size());
            exp_eng.delete();
            exp_ack.delete();
            in_fetch_req = 1'b0;
            in_load_req  = 1'b0;
            in_store_req = 1'b0;
        end
        tick(2);
    endtask

    task automatic wait_valid(input int n0, input int budget);
        int k = 0;
        while (n_valid == n0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL valid_timeout got=%0d want=%0d", n_valid, n0 + 1);
        end
    endtask

    function automatic logic [108:0] outs();
        return {out_fetch_ack, out_load_ack, out_store_ack, out_rdata,
                out_eng_valid, out_eng_rw, out_eng_addr, out_eng_size,
                out_eng_signed, out_eng_wdata};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        in_rob_misbranch = 0; in_uart_full = 0;
        in_fetch_req = 0; in_fetch_addr = '0;
        in_load_req = 0; in_load_addr = '0;
        in_load_size = '0; in_load_signed = 0;
        in_store_req = 0; in_store_addr = '0;
        in_store_size = '0; in_store_data = '0;
        tick(3);
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL reset_outs got=%h want=0", outs());
        end
        checks++;
        if (dut.state_q !== S_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d want=0", dut.state_q);
        end
        rst = 1'b0;
        tick(2);
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL idle_outs got=%h want=0", outs());
        end
    endtask

    task automatic test_single_load();
        int n0 = n_valid;
        int tr;
        use_fixed = 1; fixed_rdata = 32'hFFFF_8001; eng_lat = 3;
        exp_eng.push_back('{1'b0, 32'h100, 3'd2, 1'b1, 32'h0});
        exp_ack.push_back('{2'd2, 32'hFFFF_8001});
        in_load_addr = 32'h100; in_load_size = 3'd2; in_load_signed = 1;
        in_load_req = 1;
        tr = cyc;
        wait_quiet(60);
        checks++;
        if (t_valid !== tr + 1) begin
            failures++;
            $display("FAIL load_issue_lat got=%0d want=%0d", t_valid, tr + 1);
        end
        checks++;
        if (t_ack !== t_done + 1) begin
            failures++;
            $display("FAIL load_ack_lat got=%0d want=%0d", t_ack, t_done + 1);
        end
        checks++;
        if (n_valid !== n0 + 1) begin
            failures++;
            $display("FAIL load_nvalid got=%0d want=%0d", n_valid, n0 + 1);
        end
        checks++;
        if (out_rdata !== 32'hFFFF_8001) begin
            failures++;
            $display("FAIL load_rdata got=%h want=ffff8001", out_rdata);
        end
    endtask

    task automatic test_all_three();
        int n0 = n_valid;
        use_fixed = 0; eng_lat = 2;
        exp_eng.push_back('{1'b1, 32'h200, 3'd1, 1'b0, 32'hA5});
        exp_eng.push_back('{1'b0, 32'h104, 3'd4, 1'b0, 32'h0});
        exp_eng.push_back('{1'b0, 32'h2000, 3'd4, 1'b0, 32'h0});
        exp_ack.push_back('{2'd3, 32'h0});
        exp_ack.push_back('{2'd2, ~32'h104});
        exp_ack.push_back('{2'd1, ~32'h2000});
        in_fetch_addr = 32'h2000;
        in_load_addr = 32'h104; in_load_size = 3'd4; in_load_signed = 0;
        in_store_addr = 32'h200; in_store_size = 3'd1;
        in_store_data = 32'hA5;
        in_fetch_req = 1; in_load_req = 1; in_store_req = 1;
        wait_quiet(120);
        checks++;
        if (n_valid !== n0 + 3) begin
            failures++;
            $display("FAIL all3_nvalid got=%0d want=%0d", n_valid, n0 + 3);
        end
        checks++;
        if (out_rdata !== ~32'h2000) begin
            failures++;
            $display("FAIL all3_rdata got=%h want=%h", out_rdata, ~32'h2000);
        end
    endtask

    task automatic test_starvation();
        int n0 = n_valid;
        use_fixed = 0; eng_lat = 1;
        store_reps = 2; load_reps = 2; fetch_reps = 0;
        for (int i = 0; i < 2; i++) begin
            exp_eng.push_back('{1'b1, 32'h204, 3'd4, 1'b0, 32'h1234_5678});
            exp_eng.push_back('{1'b0, 32'h108, 3'd4, 1'b0, 32'h0});
            exp_ack.push_back('{2'd3, 32'h0});
            exp_ack.push_back('{2'd2, ~32'h108});
        end
        exp_eng.push_back('{1'b0, 32'h2400, 3'd4, 1'b0, 32'h0});
        exp_ack.push_back('{2'd1, ~32'h2400});
        exp_eng.push_back('{1'b1, 32'h204, 3'd4, 1'b0, 32'h1234_5678});
        exp_eng.push_back('{1'b0, 32'h108, 3'd4, 1'b0, 32'h0});
        exp_ack.push_back('{2'd3, 32'h0});
        exp_ack.push_back('{2'd2, ~32'h108});
        in_fetch_addr = 32'h2400;
        in_load_addr = 32'h108; in_load_size = 3'd4; in_load_signed = 0;
        in_store_addr = 32'h204; in_store_size = 3'd4;
        in_store_data = 32'h1234_5678;
        in_fetch_req = 1; in_load_req = 1; in_store_req = 1;
        wait_quiet(200);
        checks++;
        if (n_valid !== n0 + 7) begin
            failures++;
            $display("FAIL starve_nvalid got=%0d want=%0d", n_valid, n0 + 7);
        end
        checks++;
        if (dut.starve_cnt_q !== '0) begin
            failures++;
            $display("FAIL starve_cnt got=%0d want=0", dut.starve_cnt_q);
        end
    endtask

    task automatic test_uart_stall();
        int n0 = n_valid;
        int tf;
        use_fixed = 0; eng_lat = 2;
        exp_eng.push_back('{1'b1, 32'h30000, 3'd1, 1'b0, 32'h41});
        exp_eng.push_back('{1'b0, 32'h10C, 3'd1, 1'b0, 32'h0});
        exp_ack.push_back('{2'd3, 32'h0});
        exp_ack.push_back('{2'd2, ~32'h10C});
        in_uart_full = 1;
        in_store_addr = 32'h30000; in_store_size = 3'd1;
        in_store_data = 32'h41;
        in_load_addr = 32'h10C; in_load_size = 3'd1; in_load_signed = 0;
        in_store_req = 1; in_load_req = 1;
        tick(10);
        checks++;
        if (n_valid !== n0) begin
            failures++;
            $display("FAIL uart_stall_valid got=%0d want=%0d", n_valid, n0);
        end
        in_uart_full = 0;
        tf = cyc;
        wait_quiet(80);
        checks++;
        if (t_st_valid !== tf + 1) begin
            failures++;
            $display("FAIL uart_release got=%0d want=%0d", t_st_valid, tf + 1);
        end
        checks++;
        if (n_valid !== n0 + 2) begin
            failures++;
            $display("FAIL uart_nvalid got=%0d want=%0d", n_valid, n0 + 2);
        end
    endtask

    task automatic test_misbranch_busy();
        int n0 = n_valid;
        int k = 0;
        use_fixed = 1; fixed_rdata = 32'hDEAD_BEEF; eng_lat = 6;
        exp_eng.push_back('{1'b0, 32'h110, 3'd4, 1'b0, 32'h0});
        exp_eng.push_back('{1'b0, 32'h3000, 3'd4, 1'b0, 32'h0});
        exp_ack.push_back('{2'd1, 32'hDEAD_BEEF});
        in_load_addr = 32'h110; in_load_size = 3'd4; in_load_signed = 0;
        in_fetch_addr = 32'h3000;
        in_load_req = 1; in_fetch_req = 1;
        wait_valid(n0, 20);
        tick(2);
        in_rob_misbranch = 1;
        in_load_req = 0;
        tick(1);
        in_rob_misbranch = 0;
        while (busy_cnt > 0 && k < 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (out_load_ack !== 1'b0) begin
            failures++;
            $display("FAIL flush_ack got=%b want=0", out_load_ack);
        end
        checks++;
        if (out_rdata !== ~32'h10C) begin
            failures++;
            $display("FAIL flush_rdata got=%h want=%h", out_rdata, ~32'h10C);
        end
        wait_quiet(80);
        checks++;
        if (n_valid !== n0 + 2) begin
            failures++;
            $display("FAIL flush_nvalid got=%0d want=%0d", n_valid, n0 + 2);
        end
    endtask

    task automatic test_misbranch_issue();
        int n0 = n_valid;
        int tr;
        use_fixed = 0; eng_lat = 2;
        in_load_addr = 32'h114; in_load_size = 3'd4; in_load_signed = 0;
        in_load_req = 1;
        tick(1);
        in_rob_misbranch = 1;
        tick(1);
        in_rob_misbranch = 0;
        in_load_req = 0;
        tick(3);
        checks++;
        if (n_valid !== n0) begin
            failures++;
            $display("FAIL issue_abort got=%0d want=%0d", n_valid, n0);
        end
        exp_eng.push_back('{1'b0, 32'h118, 3'd2, 1'b0, 32'h0});
        exp_ack.push_back('{2'd2, ~32'h118});
        in_load_addr = 32'h118; in_load_size = 3'd2;
        in_load_req = 1;
        in_rob_misbranch = 1;
        tr = cyc;
        tick(1);
        in_rob_misbranch = 0;
        wait_quiet(60);
        checks++;
        if (t_valid !== tr + 2) begin
            failures++;
            $display("FAIL flush_vs_req got=%0d want=%0d", t_valid, tr + 2);
        end
    endtask

    task automatic test_async_reset();
        int n0 = n_valid;
        use_fixed = 0; eng_lat = 8;
        exp_eng.push_back('{1'b0, 32'h11C, 3'd4, 1'b0, 32'h0});
        in_load_addr = 32'h11C; in_load_size = 3'd4; in_load_signed = 0;
        in_load_req = 1;
        wait_valid(n0, 20);
        tick(2);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL async_rst_outs got=%h want=0", outs());
        end
        checks++;
        if (dut.state_q !== S_IDLE) begin
            failures++;
            $display("FAIL async_rst_state got=%0d want=0", dut.state_q);
        end
        in_load_req = 0;
        tick(2);
        rst = 1'b0;
        tick(2);
        eng_lat = 2;
        exp_eng.push_back('{1'b0, 32'h120, 3'd1, 1'b1, 32'h0});
        exp_ack.push_back('{2'd2, ~32'h120});
        in_load_addr = 32'h120; in_load_size = 3'd1; in_load_signed = 1;
        in_load_req = 1;
        wait_quiet(60);
        checks++;
        if (out_rdata !== ~32'h120) begin
            failures++;
            $display("FAIL post_rst_rdata got=%h want=%h", out_rdata, ~32'h120);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_all_three();
        test_starvation();
        test_uart_stall();
        test_misbranch_busy();
        test_misbranch_issue();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
